// File: rtl/mod_6_counter_struct.sv
// Modulo-6 counter with structural (bit-equation) next-state logic and self-correction from 6/7.
// Optional up/down direction input compiled in with `define MOD6_COUNTER_UPDOWN_EN.
module mod_6_counter_struct #(
    parameter logic [2:0] INIT_VALUE = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef MOD6_COUNTER_UPDOWN_EN
    input  logic       up,
`endif
    output logic [2:0] q,
    output logic       tc
);

    // Out-of-range reset values collapse to 0 so reset always lands in a legal state.
    localparam logic [2:0] INIT_EFF = (INIT_VALUE > 3'd5) ? 3'd0 : INIT_VALUE;

    logic [2:0] q_q;
    logic [2:0] q_d;
    logic       dir;
    logic       illegal;
    logic       is_zero;
    logic       is_five;
    logic       is_three;
    logic       is_four;
    logic [2:0] step_up;
    logic [2:0] step_dn;
    logic [2:0] step;

`ifdef MOD6_COUNTER_UPDOWN_EN
    assign dir = up;
`else
    assign dir = 1'b1;
`endif

    // State decodes
    assign illegal  =  q_q[2] &  q_q[1];
    assign is_zero  = ~q_q[2] & ~q_q[1] & ~q_q[0];
    assign is_three = ~q_q[2] &  q_q[1] &  q_q[0];
    assign is_four  =  q_q[2] & ~q_q[1] & ~q_q[0];
    assign is_five  =  q_q[2] & ~q_q[1] &  q_q[0];

    // Up sequence 0..5,0 ; 6/7 -> 0
    assign step_up[0] = ~q_q[0] & ~illegal;
    assign step_up[1] = ~q_q[2] & (q_q[1] ^ q_q[0]);
    assign step_up[2] = is_three | is_four;

    // Down sequence 5..0,5 ; 6/7 -> 0
    assign step_dn[0] = ~q_q[0] & ~illegal;
    assign step_dn[1] = is_three | is_four;
    assign step_dn[2] = is_zero | is_five;

    assign step[0] = (dir & step_up[0]) | (~dir & step_dn[0]);
    assign step[1] = (dir & step_up[1]) | (~dir & step_dn[1]);
    assign step[2] = (dir & step_up[2]) | (~dir & step_dn[2]);

    // Hold path is also gated by illegal so 6/7 clear even with en=0.
    assign q_d[0] = (en & step[0]) | (~en & q_q[0] & ~illegal);
    assign q_d[1] = (en & step[1]) | (~en & q_q[1] & ~illegal);
    assign q_d[2] = (en & step[2]) | (~en & q_q[2] & ~illegal);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= INIT_EFF;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign tc = en & ((dir & is_five) | (~dir & is_zero));

endmodule

// File: tb/tb_mod_6_counter_struct.sv
// Self-checking bench for mod_6_counter_struct: directed scenarios plus random en/rst/up
// against an arithmetic mod-6 reference model.
module tb_mod_6_counter_struct;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       up_s = 1'b1;
    logic [2:0] q;
    logic       tc;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned m     = 0;   // reference count
    int unsigned tc_pulses;

    localparam int unsigned INIT = 0;

    always #5 clk = ~clk;

    mod_6_counter_struct #(.INIT_VALUE(3'd0)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
`ifdef MOD6_COUNTER_UPDOWN_EN
        .up  (up_s),
`endif
        .q   (q),
        .tc  (tc)
    );

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check tc combinationally, then q after the edge.
    task automatic cyc(input logic r, input logic e, input logic u, input string tag);
        logic exp_tc;
        rst = r; en = e; up_s = u;
        #1;
        exp_tc = e && ((u && m == 5) || (!u && m == 0));
        chk({tag, "_tc"}, {2'b00, tc}, {2'b00, exp_tc});
        @(posedge clk);
        if (r)          m = INIT;
        else if (m > 5) m = 0;
        else if (e)     m = u ? (m + 1) % 6 : (m + 5) % 6;
        @(negedge clk);
        chk({tag, "_q"}, q, 3'(m));
    endtask

    task automatic force_state(input logic [2:0] v, input string tag);
        @(negedge clk);
        force dut.q_q = v;
        m = v;
        #1;
        chk({tag, "_forced"}, q, v);
        release dut.q_q;
        cyc(1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        @(negedge clk);
        // Reset for two edges, then count through a full wrap
        cyc(1'b1, 1'b1, 1'b1, "rst0");
        cyc(1'b1, 1'b0, 1'b1, "rst1");
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, "wrap");

        // Hold at 3
        cyc(1'b1, 1'b0, 1'b1, "rst2");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, "to3");
        chk("at3", q, 3'd3);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, "hold");
        cyc(1'b0, 1'b1, 1'b1, "resume");
        chk("after_hold", q, 3'd4);

        // Reset mid-count from 4
        cyc(1'b1, 1'b1, 1'b1, "midrst");
        chk("midrst_zero", q, 3'd0);
        cyc(1'b0, 1'b1, 1'b1, "postrst");
        chk("postrst_one", q, 3'd1);

        // Illegal states self-correct with en=0
        force_state(3'd7, "ill7");
        chk("ill7_zero", q, 3'd0);
        force_state(3'd6, "ill6");
        chk("ill6_zero", q, 3'd0);

        // Long run from reset: tc every 6th cycle
        cyc(1'b1, 1'b0, 1'b1, "rst3");
        tc_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            if (m == 5) tc_pulses++;
            cyc(1'b0, 1'b1, 1'b1, "long");
            total++;
            assert (q <= 3'd5) else begin
                bad++;
                $error("FAIL long_range: observed=%0d expected<=5", q);
            end
        end
        total++;
        assert (tc_pulses == 16) else begin
            bad++;
            $error("FAIL long_tc_count: observed=%0d expected=16", tc_pulses);
        end

`ifdef MOD6_COUNTER_UPDOWN_EN
        // Down count from 0, then flip direction at 2
        cyc(1'b1, 1'b0, 1'b0, "rst4");
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, "down");
        chk("down_wrap5", q, 3'd5);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, "down2");
        chk("at2", q, 3'd2);
        cyc(1'b0, 1'b1, 1'b1, "flip");
        chk("flip3", q, 3'd3);
`endif

        // Random en/rst/up against the reference model
        for (int i = 0; i < 300; i++) begin
            logic r, e, u;
            r = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
`ifdef MOD6_COUNTER_UPDOWN_EN
            u = $urandom_range(0, 1) != 0;
`else
            u = 1'b1;
`endif
            cyc(r, e, u, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_6_counter_struct.md
MOD_6_COUNTER_STRUCT -- requirements
Module: mod_6_counter_struct

Interface
REQ-001 Parameter: INIT_VALUE, default 3'd0, value loaded into q on reset; legal range 0..5.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: en  input  1  count enable; 1 = advance, 0 = hold.
REQ-005 Port: q  output  3  current count, unsigned binary 0..5.
REQ-006 Port: tc  output  1  terminal count flag, combinational.
REQ-007 Port (only when MOD6_COUNTER_UPDOWN_EN is defined): up  input  1  direction; 1 = up, 0 = down.

Function
REQ-008 The count state SHALL be held in exactly three D flip-flops, one per q bit.
REQ-009 Next-state logic SHALL be built from explicit gate-level instances or bit-level assign equations, with no behavioural "+1" or case-based counting.
REQ-010 With en=1 and counting up, q SHALL advance one step per rising clk edge: 0,1,2,3,4,5,0,...
REQ-011 Up-count wrap: on q=5 with en=1, the next edge SHALL load q=0, giving a cycle of exactly 6 clocks.
REQ-012 With en=0, q SHALL hold its value on every edge.
REQ-013 Up-count tc SHALL be 1 when q=5 and en=1, else 0.
REQ-014 Illegal states: from q=6 or q=7 the next edge SHALL load q=0, regardless of en or direction (self-correcting).
REQ-015 q SHALL change only on rising clk edges and SHALL have zero cycles of latency from en sampling to the update.

Reset
REQ-016 With rst=1 at a rising clk edge, q SHALL load INIT_VALUE; rst overrides en and up.
REQ-017 No asynchronous path from rst to q is permitted; q SHALL keep its value until the next clk edge.
REQ-018 After rst deasserts and with en=1, the first edge SHALL load INIT_VALUE+1 (mod 6).
REQ-019 Reset mid-count (any q) SHALL return q to INIT_VALUE on that edge.
REQ-020 During reset, tc SHALL follow REQ-013 and REQ-025 combinationally from the reset value of q.
REQ-021 An INIT_VALUE above 5 SHALL be treated as 0.

Configuration
REQ-022 Macro MOD6_COUNTER_UPDOWN_EN SHALL control whether the up/down feature is compiled in.
REQ-023 Macro undefined: port up SHALL be absent and the counter SHALL count up only.
REQ-024 Macro defined, up=0, en=1: q SHALL sequence 5,4,3,2,1,0,5,...; q=0 SHALL wrap to 5.
REQ-025 Macro defined, up=0: tc SHALL be 1 when q=0 and en=1.
REQ-026 Macro defined: a change of up SHALL take effect on the next edge, and the up-count behaviour SHALL be identical to the macro-undefined build.

Verification
REQ-027 Reset: rst=1 for 2 edges, then rst=0, en=1 -> q=0 during reset, then 1,2,3,4,5,0,1 on successive edges; tc=1 only while q=5.
REQ-028 Hold: count to q=3, en=0 for 4 edges -> q stays 3 and tc=0; then en=1 -> q=4.
REQ-029 Reset mid-count: q=4, assert rst for 1 edge -> q=0 on that edge; after release -> q=1 on the next edge.
REQ-030 Illegal state: force flip-flops to 7 (and separately to 6), en=0 -> q=0 on the next edge.
REQ-031 Long run: 100 clocks with en=1 from reset -> q never exceeds 5 and tc pulses every 6th cycle.
REQ-032 With MOD6_COUNTER_UPDOWN_EN defined: up=0 from q=0 -> q sequence 5,4,3,2,1,0,5 and tc=1 at q=0; toggle up=1 at q=2 -> next q=3.
